rotary_quad_decoder: RTL and testbench
======================================

// Module: rotary_quad_decoder
// PURPOSE
//  Input-side counterpart of the LED matrix display path: turns raw board rotary encoder pins
//  (A, B, push switch; all pulled up, active-low) into clean events.
//  Synchronises, debounces and quadrature-decodes them into detent step pulses,
//  a bounded position value, switch level/press pulse and an error pulse.
//  One instance per encoder, between the top-level pins and the display/control logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  27000  consecutive stable clk cycles before a pin change is accepted (1 ms @ 27 MHz)
//  POS_WIDTH        8      width of position output
//  POS_MAX          255    upper position bound (lower bound fixed at 0); must be < 2**POS_WIDTH
//  WRAP             1      1: position wraps 0<->POS_MAX; 0: saturates at the bounds
// PORTS
//  clk           in   1          system clock (27 MHz)
//  rst           in   1          asynchronous, active-high reset
//  rot_a         in   1          raw encoder A pin, asynchronous
//  rot_b         in   1          raw encoder B pin, asynchronous
//  rot_sw        in   1          raw push switch pin, active-low, asynchronous
//  pos_load      in   1          load position from pos_load_val this cycle
//  pos_load_val  in   POS_WIDTH  load value; values > POS_MAX are clamped to POS_MAX
//  step_up       out  1          1-cycle pulse: one detent clockwise
//  step_down     out  1          1-cycle pulse: one detent counter-clockwise
//  position      out  POS_WIDTH  current position
//  sw_pressed    out  1          debounced switch level, 1 = pressed
//  sw_press      out  1          1-cycle pulse on the debounced press edge
//  quad_error    out  1          1-cycle pulse on an illegal quadrature jump
// BEHAVIOUR
//  Reset: all pulse outputs 0, position 0, sw_pressed 0.
//   Debounced A/B/SW = 1 (idle). Quad state 2'b11, accumulator 0, settle counter loaded.
//  Sync: 2 flip-flops per pin.
//  Debounce per pin: a counter runs while synced != debounced and clears when they match.
//   At DEBOUNCE_CYCLES the debounced value takes the synced value.
//   Glitches shorter than DEBOUNCE_CYCLES never pass.
//  Decode on debounced {A,B}, registered prev vs cur:
//   CW sequence 11->01->00->10->11 gives acc +1 per transition; CCW is the reverse and gives -1.
//   No change: nothing happens.
//   Both bits change in one cycle: quad_error pulses and acc <= 0.
//  Detent: on a valid transition landing in 11:
//   acc_next == +4 -> step_up; acc_next == -4 -> step_down.
//   acc <= 0 in every case, which resyncs after half turns and direction reversals.
//   acc is 3-bit signed and is also cleared on error.
//  Pulse timing: every pulse is registered and is high 1 cycle after the decoding edge.
//   Pin edge to pulse latency = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//  Position:
//   step_up at POS_MAX -> 0 if WRAP, else stays at POS_MAX.
//   step_down at 0 -> POS_MAX if WRAP, else stays at 0.
//   position updates in the same cycle the pulse is asserted.
//  pos_load has priority over a simultaneous step: the value is loaded, the step pulse is still emitted
//   and is not applied to position.
//  step_up and step_down are never asserted together.
//  Settle window: for DEBOUNCE_CYCLES+3 cycles after reset release, state and debounced values track
//   but step_*, sw_press and quad_error are suppressed. Pins held non-idle through reset therefore
//   produce no spurious events.
//  sw_press fires on the debounced 1->0 edge of rot_sw only; release produces no pulse.
//  Reset asserted mid-operation clears everything immediately (async); no pulse is emitted on release.
// STRUCTURE
//  Package rotary_pkg:
//   typedef enum logic [1:0] quad_t {Q11, Q01, Q00, Q10}
//   localparam QUAD_DETENT = 2'b11, STEPS_PER_DETENT = 4
//   function quad_dir(prev, cur) returning +1, -1, 0 or error.
//  Sub-module debounce_filter #(CYCLES):
//   ports clk, rst, din, dout; includes the 2-flip-flop synchroniser; reset value of dout is 1.
//   Instantiated 3 times (A, B, SW).
//  Decode FSM, accumulator, position and settle counter live in rotary_quad_decoder.
// TESTING (bench uses DEBOUNCE_CYCLES=4, POS_MAX=9, WRAP=1 unless stated)
//  1 Idle after reset, pins held 1 for 100 cycles
//    -> no pulses, position 0, sw_pressed 0.
//  2 One CW detent (11,01,00,10,11), each level held 10 cycles
//    -> exactly one step_up, 7 cycles after the final 11 edge; position 1.
//    Same sequence reversed -> step_down, position 0.
//  3 Bounce: A toggles every 2 cycles for 20 cycles, then settles
//    -> no events during the bounce, only the settled transition is decoded.
//  4 Wrap: 10 CW detents from 0 -> position 9 then 0.
//    With WRAP=0: 12 CW detents -> position stays 9; 2 CCW from 0 -> stays 0.
//  5 Illegal jump: debounced 11->00 in one cycle -> quad_error 1 cycle, acc cleared.
//    A following full CW detent -> one step_up.
//  6 pos_load=1, pos_load_val=12 in the same cycle as a step_up
//    -> position 9 (clamped), step_up still pulses.
//    rot_sw held low 10 cycles -> sw_press once, sw_pressed 1.
//    Reset asserted mid-detent -> all outputs return to reset values.

Source files
------------

// File: rtl/rotary_pkg.sv
// rotary_pkg: shared quadrature types and direction decode for the rotary encoder path
package rotary_pkg;
  typedef enum logic [1:0] {Q11 = 2'b11, Q01 = 2'b01, Q00 = 2'b00, Q10 = 2'b10} quad_t;
  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_CW = 2'd1, DIR_ERR = 2'd2, DIR_CCW = 2'd3} dir_t;
  localparam quad_t QUAD_DETENT = Q11;
  localparam int STEPS_PER_DETENT = 4;
  // Position of a state along the CW cycle 11->01->00->10, so a step is a difference mod 4
  function automatic logic [1:0] quad_phase(input quad_t q);
    return {~q[0], q[1] ^ q[0]};
  endfunction
  function automatic dir_t quad_dir(input quad_t prev, input quad_t cur);
    logic [1:0] d;
    d = quad_phase(cur) - quad_phase(prev);
    return dir_t'(d);
  endfunction
endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: 2-flop synchroniser plus stable-count debouncer, idles high
module debounce_filter #(
  parameter int CYCLES = 27000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int CNT_W = $clog2(CYCLES + 1);
  logic [1:0] sync;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= 2'b11;
      dout <= 1'b1;
      cnt <= '0;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) cnt <= '0;
      else if (cnt == CNT_W'(CYCLES - 1)) begin
        dout <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/rotary_quad_decoder.sv
// rotary_quad_decoder: debounced quadrature decode into detent steps, bounded position and switch events
module rotary_quad_decoder
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 27000,
  parameter int POS_WIDTH = 8,
  parameter int POS_MAX = 255,
  parameter int WRAP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rot_a,
  input  logic                 rot_b,
  input  logic                 rot_sw,
  input  logic                 pos_load,
  input  logic [POS_WIDTH-1:0] pos_load_val,
  output logic                 step_up,
  output logic                 step_down,
  output logic [POS_WIDTH-1:0] position,
  output logic                 sw_pressed,
  output logic                 sw_press,
  output logic                 quad_error
);
  localparam int SETTLE = DEBOUNCE_CYCLES + 3;
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [POS_WIDTH-1:0] PMAX = POS_WIDTH'(POS_MAX);
  logic a_db, b_db, sw_db;
  quad_t prev, cur;
  dir_t dir;
  logic signed [2:0] acc;
  logic signed [3:0] acc_next;
  logic [SET_W-1:0] settle;
  logic quiet, land, up, down, err, press;
  logic [POS_WIDTH-1:0] load_val, pos_next;
  debounce_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_a (.clk(clk), .rst(rst), .din(rot_a), .dout(a_db));
  debounce_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_b (.clk(clk), .rst(rst), .din(rot_b), .dout(b_db));
  debounce_filter #(.CYCLES(DEBOUNCE_CYCLES)) u_sw (.clk(clk), .rst(rst), .din(rot_sw), .dout(sw_db));
  always_comb begin
    cur = quad_t'({a_db, b_db});
    dir = quad_dir(prev, cur);
    acc_next = 4'(acc) + (dir == DIR_CW ? 4'sd1 : dir == DIR_CCW ? -4'sd1 : 4'sd0);
    quiet = settle != '0;
    land = (dir == DIR_CW || dir == DIR_CCW) && cur == QUAD_DETENT;
    up = land && acc_next == 4'(STEPS_PER_DETENT) && !quiet;
    down = land && acc_next == -4'(STEPS_PER_DETENT) && !quiet;
    err = dir == DIR_ERR && !quiet;
    press = !sw_db && !sw_pressed && !quiet;
    load_val = pos_load_val > PMAX ? PMAX : pos_load_val;
    pos_next = pos_load ? load_val :
               up ? (position == PMAX ? (WRAP != 0 ? '0 : PMAX) : position + POS_WIDTH'(1)) :
               down ? (position == '0 ? (WRAP != 0 ? PMAX : '0) : position - POS_WIDTH'(1)) :
               position;
  end
  // Landing on the detent always clears acc so half turns and reversals resync
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev <= Q11;
      acc <= '0;
      settle <= SET_W'(SETTLE);
      step_up <= 1'b0;
      step_down <= 1'b0;
      quad_error <= 1'b0;
      sw_press <= 1'b0;
      sw_pressed <= 1'b0;
      position <= '0;
    end else begin
      prev <= cur;
      acc <= (land || dir == DIR_ERR) ? 3'sd0 : acc_next[2:0];
      settle <= quiet ? settle - SET_W'(1) : settle;
      step_up <= up;
      step_down <= down;
      quad_error <= err;
      sw_press <= press;
      sw_pressed <= !sw_db;
      position <= pos_next;
    end
endmodule

// File: tb/tb_rotary_quad_decoder.sv
// tb_rotary_quad_decoder: directed and random checks against a behavioural encoder model
module tb_rotary_quad_decoder;
  localparam int C = 4;
  localparam int PM = 9;
  logic clk = 1'b0, rst = 1'b1, rot_a = 1'b1, rot_b = 1'b1, rot_sw = 1'b1, pos_load = 1'b0;
  logic [7:0] pos_load_val = 8'd0;
  logic up1, dn1, pressed1, press1, err1, up0, dn0, pressed0, press0, err0;
  logic [7:0] pos1, pos0;
  int tests = 0, fails = 0, cyc = 0;
  int n_up = 0, n_dn = 0, n_err = 0, n_press = 0, last_up_cyc = 0, t_last = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  rotary_quad_decoder #(.DEBOUNCE_CYCLES(C), .POS_WIDTH(8), .POS_MAX(PM), .WRAP(1)) dut (
    .clk(clk), .rst(rst), .rot_a(rot_a), .rot_b(rot_b), .rot_sw(rot_sw), .pos_load(pos_load),
    .pos_load_val(pos_load_val), .step_up(up1), .step_down(dn1), .position(pos1),
    .sw_pressed(pressed1), .sw_press(press1), .quad_error(err1));
  rotary_quad_decoder #(.DEBOUNCE_CYCLES(C), .POS_WIDTH(8), .POS_MAX(PM), .WRAP(0)) dut_sat (
    .clk(clk), .rst(rst), .rot_a(rot_a), .rot_b(rot_b), .rot_sw(rot_sw), .pos_load(pos_load),
    .pos_load_val(pos_load_val), .step_up(up0), .step_down(dn0), .position(pos0),
    .sw_pressed(pressed0), .sw_press(press0), .quad_error(err0));
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // Model: pins reach the filter 2 samples late and must then hold C samples in a row
  logic [C+1:0] ha, hb, hs;
  logic da, db, ds, m_quiet, e_up, e_dn, e_err, e_press, e_pressed;
  int m_edges, m_acc, m_prev, m_cur, m_d, m_pos, m_pos0;
  function automatic int ph(input logic a, input logic b);
    return (a && b) ? 0 : (!a && b) ? 1 : (!a && !b) ? 2 : 3;
  endfunction
  function automatic logic filt(input logic [C+1:0] h, input logic d);
    for (int i = 2; i <= C + 1; i++) if (h[i] == d) return d;
    return ~d;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ha = '1; hb = '1; hs = '1; da = 1; db = 1; ds = 1;
      m_edges = 0; m_acc = 0; m_prev = 0; m_pos = 0; m_pos0 = 0;
      e_up = 0; e_dn = 0; e_err = 0; e_press = 0; e_pressed = 0;
    end else begin
      m_edges++;
      m_quiet = m_edges <= C + 3;
      m_cur = ph(da, db);
      m_d = (m_cur - m_prev + 4) % 4;
      e_up = 0; e_dn = 0; e_err = 0;
      if (m_d == 2) begin
        e_err = !m_quiet;
        m_acc = 0;
      end else if (m_d != 0) begin
        m_acc += (m_d == 1) ? 1 : -1;
        if (m_cur == 0) begin
          e_up = m_acc == 4 && !m_quiet;
          e_dn = m_acc == -4 && !m_quiet;
          m_acc = 0;
        end
      end
      e_press = !ds && !e_pressed && !m_quiet;
      e_pressed = !ds;
      if (pos_load) begin
        m_pos = pos_load_val > PM ? PM : int'(pos_load_val);
        m_pos0 = m_pos;
      end else if (e_up) begin
        m_pos = (m_pos + 1) % (PM + 1);
        m_pos0 = m_pos0 < PM ? m_pos0 + 1 : PM;
      end else if (e_dn) begin
        m_pos = (m_pos + PM) % (PM + 1);
        m_pos0 = m_pos0 > 0 ? m_pos0 - 1 : 0;
      end
      m_prev = m_cur;
      ha = {ha[C:0], rot_a}; hb = {hb[C:0], rot_b}; hs = {hs[C:0], rot_sw};
      da = filt(ha, da); db = filt(hb, db); ds = filt(hs, ds);
    end
  end
  always @(negedge clk) begin
    chk("step_up", up1, e_up);
    chk("step_down", dn1, e_dn);
    chk("quad_error", err1, e_err);
    chk("sw_press", press1, e_press);
    chk("sw_pressed", pressed1, e_pressed);
    chk("position", pos1, m_pos);
    chk("sat_step_up", up0, e_up);
    chk("sat_step_down", dn0, e_dn);
    chk("sat_quad_error", err0, e_err);
    chk("sat_sw_press", press0, e_press);
    chk("sat_sw_pressed", pressed0, e_pressed);
    chk("sat_position", pos0, m_pos0);
    n_up += int'(up1); n_dn += int'(dn1); n_err += int'(err1); n_press += int'(press1);
    if (up1) last_up_cyc = cyc;
  end
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask
  task automatic set_ph(input int p, input int hold);
    rot_a = (p == 0 || p == 3);
    rot_b = (p <= 1);
    t_last = cyc;
    wait_cyc(hold);
  endtask
  task automatic cw(input int n);
    repeat (n) begin set_ph(1, 10); set_ph(2, 10); set_ph(3, 10); set_ph(0, 10); end
  endtask
  task automatic ccw(input int n);
    repeat (n) begin set_ph(3, 10); set_ph(2, 10); set_ph(1, 10); set_ph(0, 10); end
  endtask
  task automatic load(input int v);
    pos_load = 1; pos_load_val = 8'(v);
    wait_cyc(1);
    pos_load = 0;
    wait_cyc(1);
  endtask
  initial begin
    int bu, bd, be, bp, p;
    wait_cyc(3);
    rst = 0;
    wait_cyc(100);
    chk("idle_events", n_up + n_dn + n_err + n_press, 0);
    chk("idle_position", pos1, 0);
    chk("idle_sw_pressed", pressed1, 0);
    bu = n_up; bd = n_dn;
    cw(1);
    chk("cw_one_step", n_up - bu, 1);
    chk("cw_latency", last_up_cyc - t_last, 7);
    chk("cw_position", pos1, 1);
    ccw(1);
    chk("ccw_one_step", n_dn - bd, 1);
    chk("ccw_position", pos1, 0);
    bu = n_up; bd = n_dn; be = n_err;
    for (int i = 0; i < 10; i++) begin rot_a = ~rot_a; wait_cyc(2); end
    rot_a = 0;
    wait_cyc(10);
    chk("bounce_no_events", n_up - bu + n_dn - bd + n_err - be, 0);
    set_ph(2, 10); set_ph(3, 10); set_ph(0, 10);
    chk("bounce_then_step", n_up - bu, 1);
    chk("bounce_position", pos1, 1);
    load(0);
    cw(9);
    chk("wrap_pos9", pos1, 9);
    cw(1);
    chk("wrap_pos0", pos1, 0);
    chk("sat_hold9", pos0, 9);
    cw(2);
    chk("wrap_pos2", pos1, 2);
    chk("sat_still9", pos0, 9);
    load(0);
    ccw(2);
    chk("wrap_down8", pos1, 8);
    chk("sat_floor0", pos0, 0);
    bu = n_up; be = n_err;
    set_ph(2, 10);
    chk("jump_error", n_err - be, 1);
    set_ph(3, 10); set_ph(0, 10);
    chk("half_turn_no_step", n_up - bu, 0);
    cw(1);
    chk("after_error_step", n_up - bu, 1);
    chk("single_error", n_err - be, 1);
    load(3);
    bu = n_up;
    set_ph(1, 10); set_ph(2, 10); set_ph(3, 10); set_ph(0, 6);
    pos_load = 1; pos_load_val = 8'd12;
    wait_cyc(1);
    pos_load = 0;
    wait_cyc(4);
    chk("load_clamped", pos1, 9);
    chk("load_step_still", n_up - bu, 1);
    bp = n_press;
    rot_sw = 0;
    wait_cyc(10);
    chk("sw_level", pressed1, 1);
    chk("sw_press_once", n_press - bp, 1);
    rot_sw = 1;
    wait_cyc(10);
    chk("sw_release", pressed1, 0);
    chk("sw_no_release_pulse", n_press - bp, 1);
    set_ph(1, 10); set_ph(2, 10);
    rst = 1;
    wait_cyc(1);
    chk("rst_position", pos1, 0);
    chk("rst_sat_position", pos0, 0);
    chk("rst_pulses", int'(up1) + int'(dn1) + int'(err1) + int'(press1), 0);
    bu = n_up; bd = n_dn; be = n_err;
    rst = 0;
    wait_cyc(30);
    set_ph(3, 10); set_ph(0, 10);
    chk("rst_release_quiet", n_up - bu + n_dn - bd + n_err - be, 0);
    p = 0;
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) begin pos_load = 1; pos_load_val = 8'($urandom_range(0, 15)); end
      if ($urandom_range(0, 9) == 0) rot_sw = ~rot_sw;
      if (i == 150) begin rst = 1; wait_cyc(2); rst = 0; end
      if (r < 70) p = (p + (r < 45 ? 1 : 3)) % 4;
      else if (r < 78) p = (p + 2) % 4;
      else if (r < 90) begin
        rot_a = ~rot_a;
        wait_cyc($urandom_range(1, 3));
        pos_load = 0;
        rot_a = ~rot_a;
      end
      rot_a = (p == 0 || p == 3);
      rot_b = (p <= 1);
      wait_cyc(1);
      pos_load = 0;
      wait_cyc($urandom_range(0, 9));
    end
    wait_cyc(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
